// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the pipeline and the multiply/divide timing
// sequencer.
//   master : pipeline side, drives the ctrl_* requests and observes status
//   slave  : sequencer side, receives the ctrl_* requests and drives status
// Signals:
//   ctrl_MULT / ctrl_DIV   start a multiply / divide
//   ctrl_cancel            abort the current op (flush)
//   ctrl_stall             freeze step progress
//   load                   one-cycle operand-latch pulse for the datapath
//   busy                   op in progress
//   op_is_div              accepted op is a divide
//   step                   elapsed-cycle count of the current op
//   data_resultRDY         one-cycle result-valid pulse
//   data_resultRDY_hold    sticky ready until next start/cancel/reset
interface multdiv_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             ctrl_cancel;
    logic             ctrl_stall;
    logic             load;
    logic             busy;
    logic             op_is_div;
    logic [CNT_W-1:0] step;
    logic             data_resultRDY;
    logic             data_resultRDY_hold;

    modport master (
        output ctrl_MULT, ctrl_DIV, ctrl_cancel, ctrl_stall,
        input  load, busy, op_is_div, step, data_resultRDY, data_resultRDY_hold
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, ctrl_cancel, ctrl_stall,
        output load, busy, op_is_div, step, data_resultRDY, data_resultRDY_hold
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Timing sequencer for the multicycle multiply/divide unit. A single
// up-counting step register tracks progress through the op; the op's
// latency (MULT_CYCLES or DIV_CYCLES) selects where the run ends.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-low
//   bus    multdiv_sequencer_if.slave (requests in, status out)
// Priority at each edge: reset, cancel, start, then normal progress.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no op in flight; hold may be set from the previous op
// RUN   | op in flight, step counts elapsed unstalled cycles
// DONE  | result valid this cycle (single-cycle ready pulse)
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 17,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    multdiv_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last step value seen in RUN; the following unstalled edge enters DONE.
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] step_q;
    logic             load_q;
    logic             op_is_div_q;
    logic             hold_q;

    logic             start;
    logic             start_div;
    logic [CNT_W-1:0] last_step;

    // Multiply wins when both requests are high.
    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign last_step = op_is_div_q ? DIV_LAST : MULT_LAST;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            load_q      <= 1'b0;
            op_is_div_q <= 1'b0;
            hold_q      <= 1'b0;
        end else if (bus.ctrl_cancel) begin
            // op_is_div keeps its value; only a new start changes it.
            state_q <= IDLE;
            step_q  <= '0;
            load_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else if (start) begin
            // Accepted from any state; a start in RUN silently restarts.
            state_q     <= RUN;
            step_q      <= STEP_ONE;
            load_q      <= 1'b1;
            op_is_div_q <= start_div;
            hold_q      <= 1'b0;
        end else begin
            load_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (!bus.ctrl_stall) begin
                        if (step_q == last_step) begin
                            state_q <= DONE;
                            step_q  <= '0;
                        end else begin
                            step_q <= step_q + STEP_ONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.load                = load_q;
    assign bus.busy                = (state_q == RUN);
    assign bus.op_is_div           = op_is_div_q;
    assign bus.step                = step_q;
    assign bus.data_resultRDY      = (state_q == DONE);
    assign bus.data_resultRDY_hold = hold_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    localparam int CNT_W = 6;

    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    multdiv_sequencer_if #(.CNT_W(CNT_W)) bus  ();
    multdiv_sequencer_if #(.CNT_W(CNT_W)) bus2 ();

    multdiv_sequencer #(
        .MULT_CYCLES(17), .DIV_CYCLES(33), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    multdiv_sequencer #(
        .MULT_CYCLES(2), .DIV_CYCLES(33), .CNT_W(CNT_W)
    ) dut_short (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit sel,
                              input bit ld, input bit bs, input bit dv,
                              input int st, input bit rdy, input bit hd);
        if (!sel) begin
            chk({tag, ".load"}, 32'(bus.load), 32'(ld));
            chk({tag, ".busy"}, 32'(bus.busy), 32'(bs));
            chk({tag, ".div"},  32'(bus.op_is_div), 32'(dv));
            chk({tag, ".step"}, 32'(bus.step), 32'(st));
            chk({tag, ".rdy"},  32'(bus.data_resultRDY), 32'(rdy));
            chk({tag, ".hold"}, 32'(bus.data_resultRDY_hold), 32'(hd));
        end else begin
            chk({tag, ".load"}, 32'(bus2.load), 32'(ld));
            chk({tag, ".busy"}, 32'(bus2.busy), 32'(bs));
            chk({tag, ".div"},  32'(bus2.op_is_div), 32'(dv));
            chk({tag, ".step"}, 32'(bus2.step), 32'(st));
            chk({tag, ".rdy"},  32'(bus2.data_resultRDY), 32'(rdy));
            chk({tag, ".hold"}, 32'(bus2.data_resultRDY_hold), 32'(hd));
        end
    endtask

    // Drive a start for cycle 0; returns in cycle 1.
    task automatic start_op(input bit m, input bit d);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV  = d;
        tick();
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    // Unstalled op already in cycle 1: check cycles 1..n+1.
    task automatic run_plain(input string tag, input int n, input bit dv);
        for (int c = 1; c < n; c++) begin
            expect_out($sformatf("%s c%0d", tag, c), 1'b0, c == 1, 1'b1, dv, c, 1'b0, 1'b0);
            tick();
        end
        expect_out($sformatf("%s c%0d", tag, n), 1'b0, 1'b0, 1'b0, dv, 0, 1'b1, 1'b0);
        tick();
        expect_out($sformatf("%s c%0d", tag, n + 1), 1'b0, 1'b0, 1'b0, dv, 0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        bus.ctrl_MULT = 0; bus.ctrl_DIV = 0; bus.ctrl_cancel = 0; bus.ctrl_stall = 0;
        bus2.ctrl_MULT = 0; bus2.ctrl_DIV = 0; bus2.ctrl_cancel = 0; bus2.ctrl_stall = 0;
        tick(); tick();
        expect_out("reset", 1'b0, 0, 0, 0, 0, 0, 0);
        expect_out("reset2", 1'b1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        expect_out("idle", 1'b0, 0, 0, 0, 0, 0, 0);

        // Multiply, default latency 17.
        start_op(1, 0);
        run_plain("mul", 17, 1'b0);
        tick(); tick();
        expect_out("mul hold", 1'b0, 0, 0, 0, 0, 0, 1);

        // Divide, latency 33 (includes no pulse in cycle 17).
        start_op(0, 1);
        run_plain("div", 33, 1'b1);

        // Multiply with stall on edges ending cycles 5,6,7.
        start_op(1, 0);
        for (int c = 1; c <= 19; c++) begin
            int est;
            est = (c <= 5) ? c : ((c <= 8) ? 5 : c - 3);
            expect_out($sformatf("stall c%0d", c), 1'b0, c == 1, 1'b1, 1'b0, est, 1'b0, 1'b0);
            bus.ctrl_stall = (c >= 5 && c <= 7);
            tick();
        end
        expect_out("stall c20", 1'b0, 0, 0, 0, 0, 1, 0);
        bus.ctrl_stall = 1'b1;   // ignored in DONE
        tick();
        bus.ctrl_stall = 1'b0;
        expect_out("stall c21", 1'b0, 0, 0, 0, 0, 0, 1);

        // Both starts high: multiply wins.
        start_op(1, 1);
        run_plain("both", 17, 1'b0);

        // Start together with cancel: nothing accepted, hold cleared.
        bus.ctrl_MULT = 1'b1; bus.ctrl_cancel = 1'b1;
        tick();
        bus.ctrl_MULT = 1'b0; bus.ctrl_cancel = 1'b0;
        expect_out("startcancel", 1'b0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("startcancel+1", 1'b0, 0, 0, 0, 0, 0, 0);

        // Restart: multiply at 0, divide at 10, ready at 43.
        start_op(1, 0);
        for (int c = 1; c <= 9; c++) begin
            expect_out($sformatf("rst c%0d", c), 1'b0, c == 1, 1, 0, c, 0, 0);
            tick();
        end
        expect_out("rst c10", 1'b0, 0, 1, 0, 10, 0, 0);
        start_op(0, 1);
        run_plain("rstdiv", 33, 1'b1);

        // Cancel at cycle 8: no ready ever.
        start_op(1, 0);
        for (int c = 1; c <= 7; c++) tick();
        expect_out("cancel c8", 1'b0, 0, 1, 0, 8, 0, 0);
        bus.ctrl_cancel = 1'b1;
        tick();
        bus.ctrl_cancel = 1'b0;
        expect_out("cancel c9", 1'b0, 0, 0, 0, 0, 0, 0);
        for (int c = 10; c <= 25; c++) begin
            tick();
            chk($sformatf("cancel c%0d.rdy", c), 32'(bus.data_resultRDY), 32'd0);
        end

        // Reset at cycle 12 of a divide.
        start_op(0, 1);
        for (int c = 1; c <= 11; c++) tick();
        expect_out("reset c12", 1'b0, 0, 1, 1, 12, 0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_out("reset c13", 1'b0, 0, 0, 0, 0, 0, 0);
        for (int c = 14; c <= 40; c++) begin
            tick();
            chk($sformatf("reset c%0d.rdy", c), 32'(bus.data_resultRDY), 32'd0);
        end

        // Start accepted in the DONE cycle: hold stays 0, new op runs.
        start_op(1, 0);
        for (int c = 1; c <= 16; c++) tick();
        expect_out("done c17", 1'b0, 0, 0, 0, 0, 1, 0);
        start_op(0, 1);
        run_plain("donestart", 33, 1'b1);

        // Boundary MULT_CYCLES=2, then start in its DONE cycle.
        bus2.ctrl_MULT = 1'b1;
        tick();
        bus2.ctrl_MULT = 1'b0;
        expect_out("short c1", 1'b1, 1, 1, 0, 1, 0, 0);
        tick();
        expect_out("short c2", 1'b1, 0, 0, 0, 0, 1, 0);
        tick();
        expect_out("short c3", 1'b1, 0, 0, 0, 0, 0, 1);
        bus2.ctrl_MULT = 1'b1;
        tick();
        bus2.ctrl_MULT = 1'b0;
        expect_out("short2 c1", 1'b1, 1, 1, 0, 1, 0, 0);
        tick();
        expect_out("short2 c2", 1'b1, 0, 0, 0, 0, 1, 0);
        bus2.ctrl_MULT = 1'b1;
        tick();
        bus2.ctrl_MULT = 1'b0;
        expect_out("short3 c1", 1'b1, 1, 1, 0, 1, 0, 0);
        tick();
        expect_out("short3 c2", 1'b1, 0, 0, 0, 0, 1, 0);
        tick();
        expect_out("short3 c3", 1'b1, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
